// File: rtl/fdiv_norm_seq.sv
// Post-divide normalizer: leading-zero count, left shift and exponent adjust, one operand at a time.
// Define FDIV_NORM_BYPASS_EN to send already-normalized operands (MSB set) straight to DONE.
module fdiv_norm_seq #(
    parameter int WIDTH = 32,
    parameter int EXP_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mant,
    input  logic [EXP_W-1:0] in_exp,
    input  logic             in_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_sign,
    output logic             out_zero,
    output logic             out_uflow
);

    localparam int LZC_W = 5;

`ifdef FDIV_NORM_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] mant_r;
    logic [EXP_W-1:0] exp_r;
    logic             sign_r;
    logic [LZC_W-1:0] lzc_r;
    logic             zero_r;

    logic             take_bypass;
    logic             load_res;

    logic [WIDTH-1:0] src_mant;
    logic [EXP_W-1:0] src_exp;
    logic             src_sign;
    logic [LZC_W-1:0] src_lzc;
    logic             src_zero;
    logic [EXP_W:0]   exp_adj;
    logic [WIDTH-1:0] res_mant;
    logic [EXP_W-1:0] res_exp;
    logic             res_uflow;

    function automatic logic [LZC_W-1:0] count_lz(input logic [WIDTH-1:0] m);
        logic [LZC_W-1:0] n;
        logic             found;
        n     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found && m[WIDTH-1-i]) begin
                n     = i[LZC_W-1:0];
                found = 1'b1;
            end
        end
        return n;
    endfunction

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign take_bypass = BYPASS && in_mant[WIDTH-1];
    assign load_res    = (state == SHIFT) || ((state == IDLE) && in_valid && take_bypass);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_n = take_bypass ? DONE : COUNT;
                end
            end
            COUNT:   state_n = SHIFT;
            SHIFT:   state_n = DONE;
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The bypass path feeds the live inputs (lzc forced to 0) through the same result logic as SHIFT,
    // so bypassed and normal operands produce bit-identical outputs.
    always_comb begin
        src_mant = mant_r;
        src_exp  = exp_r;
        src_sign = sign_r;
        src_lzc  = lzc_r;
        src_zero = zero_r;
        if (state == IDLE) begin
            src_mant = in_mant;
            src_exp  = in_exp;
            src_sign = in_sign;
            src_lzc  = '0;
            src_zero = 1'b0;
        end

        exp_adj   = {src_exp[EXP_W-1], src_exp} - {{(EXP_W+1-LZC_W){1'b0}}, src_lzc};
        res_mant  = src_mant << src_lzc;
        res_exp   = exp_adj[EXP_W-1:0];
        res_uflow = 1'b0;

        if (src_zero) begin
            res_mant = '0;
            res_exp  = '0;
        end else if (exp_adj[EXP_W] || (exp_adj == '0)) begin
            res_exp   = '0;
            res_uflow = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mant_r <= '0;
            exp_r  <= '0;
            sign_r <= 1'b0;
            lzc_r  <= '0;
            zero_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mant_r <= in_mant;
                        exp_r  <= in_exp;
                        sign_r <= in_sign;
                    end
                end
                COUNT: begin
                    lzc_r  <= count_lz(mant_r);
                    zero_r <= (mant_r == '0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_mant  <= '0;
            out_exp   <= '0;
            out_sign  <= 1'b0;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
        end else if (load_res) begin
            out_mant  <= res_mant;
            out_exp   <= res_exp;
            out_sign  <= src_sign;
            out_zero  <= src_zero;
            out_uflow <= res_uflow;
        end
    end

endmodule

// File: doc/fdiv_norm_seq.md
FDIV_NORM_SEQ -- requirements
Module: fdiv_norm_seq

Interface
REQ-001 Parameter: WIDTH, 32, mantissa width; fixed at 32 in this revision.
REQ-002 Parameter: EXP_W, 9, exponent width; signed two's complement, biased.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: in_valid  input  1  upstream operand valid.
REQ-006 Port: in_ready  output  1  block can accept an operand.
REQ-007 Port: in_mant  input  WIDTH  unnormalized quotient mantissa.
REQ-008 Port: in_exp  input  EXP_W  quotient exponent before normalization.
REQ-009 Port: in_sign  input  1  quotient sign.
REQ-010 Port: out_valid  output  1  result valid.
REQ-011 Port: out_ready  input  1  downstream accepts result.
REQ-012 Port: out_mant  output  WIDTH  normalized mantissa; bit WIDTH-1 is 1 unless out_zero.
REQ-013 Port: out_exp  output  EXP_W  adjusted exponent.
REQ-014 Port: out_sign  output  1  registered copy of in_sign.
REQ-015 Port: out_zero  output  1  in_mant was all zeros.
REQ-016 Port: out_uflow  output  1  adjusted exponent was <= 0.

Function
REQ-017 FSM states: IDLE, COUNT, SHIFT, DONE.
REQ-018 in_ready SHALL be 1 only in IDLE.
REQ-019 IDLE: on in_valid=1, capture in_mant, in_exp and in_sign, then go to COUNT.
REQ-020 COUNT: register the leading-zero count lzc (5 bits; 0 means MSB set) and a zero flag; go to SHIFT.
REQ-021 SHIFT: mant = mant << lzc; exp_adj = in_exp - lzc, computed at EXP_W+1 bits signed; go to DONE.
REQ-022 Zero operand: out_zero=1, out_mant=0, out_exp=0, out_uflow=0; the shift and exponent adjust are skipped.
REQ-023 exp_adj <= 0: out_uflow=1 and out_exp=0; out_mant still holds the normalized value (no denormal handling).
REQ-024 DONE: out_valid=1; outputs SHALL stay stable while out_ready=0.
REQ-025 DONE with out_ready=1: return to IDLE next cycle; no accept in that same cycle.
REQ-026 Latency: accept at edge N; out_valid=1 from edge N+3. Max throughput is one result per 4 cycles.
REQ-027 in_valid while not in IDLE SHALL be ignored; upstream holds its data.
REQ-028 in_mant = 0x80000000: lzc=0, out_mant equals in_mant, out_exp equals in_exp.
REQ-029 in_mant = 0x00000001: lzc=31, out_mant=0x80000000, out_exp = in_exp-31.

Reset
REQ-030 rst=1 at a clock edge: state IDLE; out_valid, out_mant, out_exp, out_sign, out_zero and out_uflow all 0.
REQ-031 rst=1 mid-operation (COUNT, SHIFT or DONE) SHALL discard the in-flight operand with no out_valid pulse.
REQ-032 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-033 Macro FDIV_NORM_BYPASS_EN defined: an operand captured with in_mant[WIDTH-1]=1 SHALL go IDLE->DONE directly, giving latency 1 (out_valid at edge N+1) with lzc=0.
REQ-034 Macro FDIV_NORM_BYPASS_EN undefined: every operand SHALL traverse COUNT and SHIFT (latency 3).
REQ-035 Outputs for a given operand SHALL be identical with and without the macro; only latency differs.

Verification
REQ-036 in_mant=0x00010000, in_exp=130, sign=1, out_ready=1 -> out_mant=0x80000000, out_exp=115, out_sign=1, out_valid at +3.
REQ-037 in_mant=0, in_exp=100 -> out_zero=1, out_mant=0, out_exp=0, out_uflow=0.
REQ-038 in_mant=0x00000001, in_exp=20 -> out_mant=0x80000000, out_uflow=1, out_exp=0.
REQ-039 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE, next operand accepted.
REQ-040 rst=1 in the SHIFT state -> next cycle IDLE, out_valid=0, all outputs 0, no result emitted.
REQ-041 With FDIV_NORM_BYPASS_EN, in_mant=0xC0000000, in_exp=127 -> out_valid at +1, out_mant=0xC0000000, out_exp=127; without the macro -> the same values at +3.
